// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// A one-word holding buffer lets consecutive frames go out back to back.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  dout,
    output logic                  busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    dout_q, dout_d;

    logic accept;
    logic bit_end;
    logic load_direct;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            dout_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            dout_q     <= dout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        accept      = tx_valid && !buf_full_q;
        bit_end     = (cnt_q == CNT_LAST);
        load_direct = (state_q == IDLE) || ((state_q == STOP) && bit_end);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                        state_d    = START;
                    end else if (accept) begin
                        shift_d = tx_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A word arriving while the shifter is mid-frame parks in the buffer.
        if (accept && !load_direct) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        // dout is registered from the next state so the line changes on the
        // same edge as the FSM, with no combinational path from tx_data.
        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = shift_d[idx_d];
            default: dout_d = 1'b1;
        endcase
    end

    // Output logic.
    always_comb begin
        tx_ready = !buf_full_q;
        busy     = (state_q != IDLE);
        dout     = dout_q;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (8 data bits, 16 clocks per bit).
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .dout    (dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected line level k cycles into a frame sequence (160 cycles per frame).
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        int p;
        p = (k % 160) / 16;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return d[p-1];
    endfunction

    task automatic test_reset_single();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tick();
        tick();
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL reset_dout got=%b exp=1", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        reset    = 1'b0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 160; k++) begin
            checks++;
            if (dout !== exp_bit(8'h55, k)) begin
                errors++; $display("FAIL single_dout k=%0d got=%b exp=%b", k, dout, exp_bit(8'h55, k));
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got=%b exp=0", busy); end
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL single_end_dout got=%b exp=1", dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        logic [7:0] rx [2];
        logic       exp_rdy;
        int         f, p;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        rx[0]    = 8'h00;
        rx[1]    = 8'h00;
        do_reset();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h3C;
        for (int k = 0; k < 320; k++) begin
            f = k / 160;
            p = (k % 160) / 16;
            checks++;
            if (dout !== exp_bit(words[f], k)) begin
                errors++; $display("FAIL b2b_dout k=%0d got=%b exp=%b", k, dout, exp_bit(words[f], k));
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=1", k, busy); end
            exp_rdy = (k == 0) || (k >= 160);
            checks++;
            if (tx_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, tx_ready, exp_rdy);
            end
            if ((k % 16) == 8 && p >= 1 && p <= 8) rx[f][p-1] = dout;
            if (k == 1) tx_valid = 1'b0;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
        checks++; if (rx[0] !== 8'hA5) begin errors++; $display("FAIL b2b_word0 got=%h exp=a5", rx[0]); end
        checks++; if (rx[1] !== 8'h3C) begin errors++; $display("FAIL b2b_word1 got=%h exp=3c", rx[1]); end
    endtask

    task automatic test_third_word_stall();
        logic [7:0] words [3];
        logic       exp_rdy;
        int         f;
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        do_reset();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h02;
        for (int k = 0; k < 480; k++) begin
            f = k / 160;
            checks++;
            if (dout !== exp_bit(words[f], k)) begin
                errors++; $display("FAIL stall_dout k=%0d got=%b exp=%b", k, dout, exp_bit(words[f], k));
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy k=%0d got=%b exp=1", k, busy); end
            // Buffer drains at k=160; the third word is taken on the next edge.
            exp_rdy = (k == 0) || (k == 160) || (k >= 320);
            checks++;
            if (tx_ready !== exp_rdy) begin
                errors++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, tx_ready, exp_rdy);
            end
            if (k == 1) tx_data = 8'h03;
            if (k == 161) tx_valid = 1'b0;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy got=%b exp=0", busy); end
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL stall_end_dout got=%b exp=1", dout); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h00;
        for (int k = 0; k < 70; k++) begin
            if (k == 1) tx_valid = 1'b0;
            tick();
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre_ready got=%b exp=0", tx_ready); end
        // tx_valid asserted during reset must be ignored.
        reset    = 1'b1;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick();
        reset    = 1'b0;
        tx_valid = 1'b0;
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL midrst_dout got=%b exp=1", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", tx_ready); end
        for (int k = 0; k < 200; k++) begin
            tick();
            checks++;
            if (dout !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet k=%0d dout=%b busy=%b exp dout=1 busy=0", k, dout, busy);
            end
        end
    endtask

    task automatic test_idle_boundary();
        logic [7:0] words [2];
        int         f;
        words[0] = 8'hC3;
        words[1] = 8'h81;
        do_reset();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 320; k++) begin
            f = k / 160;
            checks++;
            if (dout !== exp_bit(words[f], k)) begin
                errors++; $display("FAIL edge_dout k=%0d got=%b exp=%b", k, dout, exp_bit(words[f], k));
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL edge_busy k=%0d got=%b exp=1", k, busy); end
            checks++;
            if (tx_ready !== 1'b1) begin errors++; $display("FAIL edge_ready k=%0d got=%b exp=1", k, tx_ready); end
            if (k == 159) begin
                tx_data  = 8'h81;
                tx_valid = 1'b1;
            end
            if (k == 160) tx_valid = 1'b0;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_end_busy got=%b exp=0", busy); end
    endtask

    // Independent receiver: find the start edge, then sample each bit mid-period.
    task automatic test_loopback();
        logic [7:0] par_out;
        int         wait_cnt;
        logic       start_s, stop_s;
        par_out = 8'h00;
        start_s = 1'b1;
        stop_s  = 1'b0;
        do_reset();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_cnt = 0;
        while (dout !== 1'b0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (dout !== 1'b0) begin
            errors++; $display("FAIL loop_start_timeout got=%b exp=0", dout);
        end else begin
            for (int k = 0; k < 160; k++) begin
                if (k == 8) start_s = dout;
                if (k >= 24 && k < 152 && ((k - 24) % 16) == 0) par_out[(k - 24) / 16] = dout;
                if (k == 152) stop_s = dout;
                tick();
            end
            checks++; if (start_s !== 1'b0) begin errors++; $display("FAIL loop_start got=%b exp=0", start_s); end
            checks++; if (stop_s !== 1'b1) begin errors++; $display("FAIL loop_stop got=%b exp=1", stop_s); end
            checks++; if (par_out !== 8'h55) begin errors++; $display("FAIL loop_par_out got=%h exp=55", par_out); end
        end
    endtask

    initial begin
        test_reset_single();
        test_back_to_back();
        test_third_word_stall();
        test_reset_mid_frame();
        test_idle_boundary();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: the transmit-side counterpart of uart_rx.
- Accepts parallel words over a valid/ready handshake and drives an 8N1-style frame on a single serial line: start bit, DATA_WIDTH data bits LSB first, one stop bit.
- Contains a one-word holding buffer so that back-to-back words go out with no idle gap.
- Bit timing matches uart_rx: CLKS_PER_BIT clock cycles per bit.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_WIDTH  parallel word to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial line; idle high.
- busy  output  1  a frame is in progress (start, data or stop bit).

Behaviour:
- Reset (synchronous, sampled at the clock edge while reset=1):
  - dout=1, busy=0, tx_ready=1.
  - Holding buffer empty; FSM to IDLE; bit and cycle counters cleared.
  - tx_valid is ignored while reset=1.
  - Reset mid-frame aborts the frame immediately: dout=1 on the next cycle, and any buffered word is discarded.
- Handshake:
  - A word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready = holding buffer empty. The register is updated so that it reflects buffer state in the same cycle.
  - tx_data must be stable only in the accept cycle.
- Accept routing:
  - If the shifter is idle, or is in the last cycle of its stop bit, the word loads directly into the shift register. The buffer stays empty.
  - Otherwise the word goes into the holding buffer and tx_ready=0 from the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: dout=1, busy=0. On accept go to START. dout=0 and busy=1 are visible from the cycle after the accept edge.
  - START: dout=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: dout = shift[index] for CLKS_PER_BIT cycles per bit. Index runs 0..DATA_WIDTH-1, then go to STOP.
  - STOP: dout=1 for CLKS_PER_BIT cycles. On the last cycle:
    - if the buffer is full, move the buffer into the shifter, go to START, clear the buffer and set tx_ready=1 next cycle;
    - else if an accept happens this same edge, load it and go to START;
    - else go to IDLE, busy=0.
- Cycle counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary.
  - The bit index counter never exceeds DATA_WIDTH-1.
- Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- Consecutive frames have zero idle cycles when the buffer is full: the stop bit's last cycle is followed directly by the start bit.
- dout is driven from a register; there are no combinational paths from tx_data to dout.
- busy stays high continuously across back-to-back frames.
- At most two words are in flight: one in the shifter and one in the buffer. A third word waits with tx_ready=0.

Test Plan:
1. Reset then single word:
   - reset=1 for 2 cycles, then tx_data=8'h55 with tx_valid=1 for 1 cycle.
   - dout=0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then 1 for 16 cycles.
   - busy high for exactly 160 cycles, then dout=1 and busy=0.
2. Back-to-back:
   - Present 8'hA5, then 8'h3C, holding tx_valid high.
   - The second word is accepted in the cycle after the first; tx_ready=0 until the first frame's stop bit ends.
   - The second start bit begins on the cycle right after the first stop bit (320 contiguous busy cycles).
   - The serial bit stream decodes as A5 then 3C.
3. Third word stall:
   - Hold tx_valid=1 with words 01, 02, 03.
   - 03 is accepted only on the cycle where the buffer drains (cycle 160 of frame 1).
   - All three frames are emitted in order with no gaps.
4. Reset mid-frame:
   - Assert reset during data bit 3 of 8'hFF, with a buffered 8'h00.
   - dout=1 and busy=0 the next cycle; tx_ready=1.
   - No further frame is emitted; the buffered word is lost.
5. Idle-boundary accept:
   - Assert tx_valid with 8'h81 exactly in the last stop-bit cycle of a frame, with the buffer empty.
   - The next frame starts with no idle cycle, and the buffer stays empty (tx_ready stays 1).
6. Loopback:
   - Feed dout into uart_rx with CLKS_PER_BIT=16 and send 8'h55.
   - uart_rx par_out=8'h55 after the stop bit.
